// File: rtl/high_score_table_pkg.sv
// Shared types and constants for the high-score leaderboard.
package hs_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, SHIFT, WRITE} state_e;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [2:0] FINISH_MODE_DFLT = 3'b101;

  // gfedcba, active high; index = decimal digit
  localparam logic [9:0][6:0] SEG7 = {
    7'b1101111, 7'b1111111, 7'b0000111, 7'b1111101, 7'b1101101,
    7'b1100110, 7'b1001111, 7'b1011011, 7'b0000110, 7'b0111111
  };
  localparam logic [6:0] SEG7_BLANK = 7'b0000000;

endpackage

// File: rtl/high_score_table_if.sv
// Bus bundle between the leaderboard and its game-side neighbours.
interface high_score_table_if #(
  parameter int DIGITS = 2,
  parameter int DEPTH  = 4,
  parameter int MODE_W = 3
);
  localparam int SW = 4*DIGITS;
  localparam int IW = $clog2(DEPTH);

  logic [SW-1:0]       score;
  logic [MODE_W-1:0]   mode;
  logic                next_entry;
  logic [SW-1:0]       highest_score;
  logic [IW-1:0]       view_idx;
  logic [IW:0]         rank;
  logic                busy;
  logic [7*DIGITS-1:0] SS_disp;

  modport master (output score, mode, next_entry,
                  input  highest_score, view_idx, rank, busy, SS_disp);
  modport slave  (input  score, mode, next_entry,
                  output highest_score, view_idx, rank, busy, SS_disp);
endinterface

// File: rtl/high_score_table_seg7.sv
// One BCD digit to seven segments; non-decimal codes go blank.
module bcd_to_seg7
  import hs_pkg::*;
(
  input  bcd_digit_t  d_i,
  output logic [6:0]  seg_o
);
  always_comb begin
    seg_o = SEG7_BLANK;
    if (d_i <= 4'd9) seg_o = SEG7[d_i];
  end
endmodule

// File: rtl/high_score_table.sv
// Sorted top-DEPTH BCD leaderboard with scan/shift insert and 7-seg readout.
// Optional display blink of the newest entry under macro HS_BLINK_EN.
module high_score_table
  import hs_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int DEPTH  = 4,
  parameter int MODE_W = 3,
  parameter logic [MODE_W-1:0] FINISH_MODE = MODE_W'(FINISH_MODE_DFLT)
`ifdef HS_BLINK_EN
 ,parameter int BLINK_DIV = 24
`endif
)(
  input logic               clk,
  input logic               n_rst,
  high_score_table_if.slave hs
);
  localparam int SW = 4*DIGITS;
  localparam int IW = $clog2(DEPTH);
  localparam logic [IW-1:0] LAST = IW'(DEPTH-1);

  state_e                   state_q, state_d;
  logic [DEPTH-1:0][SW-1:0] tbl_q;
  logic [SW-1:0]            cand_q;
  logic [IW-1:0]            idx_q, pos_q, ptr_q, view_q;
  logic [IW:0]              rank_q;
  logic                     fin_q, place_q;
  logic                     is_fin, trig, hit, busy, blank;

  assign is_fin = (hs.mode == FINISH_MODE);
  assign trig   = is_fin && !fin_q && (state_q == IDLE);
  assign hit    = cand_q > tbl_q[idx_q];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // A final miss still passes through WRITE so rank settles in the same slot as an insert.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (trig) state_d = SCAN;
      SCAN:  if (hit || idx_q == LAST) state_d = hit ? SHIFT : WRITE;
      SHIFT: if (ptr_q == pos_q) state_d = WRITE;
      WRITE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tbl_q   <= '0;
      cand_q  <= '0;
      idx_q   <= '0;
      pos_q   <= '0;
      ptr_q   <= '0;
      view_q  <= '0;
      rank_q  <= '0;
      fin_q   <= 1'b0;
      place_q <= 1'b0;
    end else begin
      fin_q <= is_fin;
      if (hs.next_entry) view_q <= (view_q == LAST) ? '0 : view_q + 1'b1;
      case (state_q)
        IDLE: if (trig) begin
          cand_q <= hs.score;
          idx_q  <= '0;
        end
        SCAN: begin
          if (hit) begin
            pos_q   <= idx_q;
            ptr_q   <= LAST;
            place_q <= 1'b1;
          end else if (idx_q == LAST) begin
            place_q <= 1'b0;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        SHIFT: if (ptr_q != pos_q) begin
          tbl_q[ptr_q] <= tbl_q[ptr_q - 1'b1];
          ptr_q        <= ptr_q - 1'b1;
        end
        WRITE: begin
          if (place_q) tbl_q[pos_q] <= cand_q;
          rank_q <= place_q ? ({1'b0, pos_q} + 1'b1) : '0;
        end
        default: ;
      endcase
    end
  end

`ifdef HS_BLINK_EN
  logic [BLINK_DIV-1:0] blink_q;
  logic                 new_q;
  logic [IW-1:0]        new_pos_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      blink_q   <= '0;
      new_q     <= 1'b0;
      new_pos_q <= '0;
    end else begin
      blink_q <= blink_q + 1'b1;
      if (state_q == WRITE && place_q) begin
        new_q     <= 1'b1;
        new_pos_q <= pos_q;
      end else if (hs.next_entry || trig) begin
        new_q <= 1'b0;
      end
    end
  end

  assign blank = new_q && (view_q == new_pos_q) && blink_q[BLINK_DIV-1];
`else
  assign blank = 1'b0;
`endif

  logic [SW-1:0]            view_score;
  logic [DIGITS-1:0][6:0]   seg;

  assign view_score = tbl_q[view_q];

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_to_seg7 u_seg (
      .d_i   (bcd_digit_t'(view_score[4*g +: 4])),
      .seg_o (seg[g])
    );
  end

  assign hs.highest_score = tbl_q[0];
  assign hs.view_idx      = view_q;
  assign hs.rank          = rank_q;
  assign hs.busy          = busy;
  assign hs.SS_disp       = blank ? '0 : seg;

endmodule
